// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder with three read/write control registers and one
// read-only ID register. Read and write paths run independently and every
// handshake/response output comes straight from a flop.
module axi_lite_slave_regs #(
  parameter logic [31:0] ID_VALUE  = 32'hA11E_0001,
  parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] reg0_out,
  output logic [31:0] reg1_out,
  output logic [31:0] reg2_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]       aw_idx_q;
  logic             aw_held_q, awready_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             w_held_q, wready_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic [2:0][31:0] regs_q, regs_d;
  logic             arready_q, rvalid_q;
  logic [31:0]      rdata_q, rsel;

  logic aw_hs, w_hs, ar_hs, commit;
  logic unused_addr_bits;

  assign aw_hs  = awvalid & awready_q;
  assign w_hs   = wvalid & wready_q;
  assign ar_hs  = arvalid & arready_q;
  // A pending response blocks the next commit so bresp never changes under bvalid.
  assign commit = aw_held_q & w_held_q & ~bvalid_q;

  // Byte-lane offsets within a 32-bit register are not addressable.
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  // Capture the write address and hold it until the write commits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_idx_q  <= 2'd0;
      aw_held_q <= 1'b0;
      awready_q <= 1'b1;
    end else if (aw_hs) begin
      aw_idx_q  <= awaddr[3:2];
      aw_held_q <= 1'b1;
      awready_q <= 1'b0;
    end else if (commit) begin
      aw_held_q <= 1'b0;
      awready_q <= 1'b1;
    end
  end

  // Capture write data/strobes and hold them until the write commits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      w_held_q <= 1'b0;
      wready_q <= 1'b1;
    end else if (w_hs) begin
      wdata_q  <= wdata;
      wstrb_q  <= wstrb;
      w_held_q <= 1'b1;
      wready_q <= 1'b0;
    end else if (commit) begin
      w_held_q <= 1'b0;
      wready_q <= 1'b1;
    end
  end

  // Merge strobed bytes into the addressed control register; register 3 is read-only.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      for (int r = 0; r < 3; r++) begin
        if (aw_idx_q == 2'(r)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) regs_d[r][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Control register file.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) regs_q <= {3{REG_RESET}};
    else          regs_q <= regs_d;
  end

  // Write response: raised on commit, held until the master takes it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= (aw_idx_q == 2'd3) ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read mux; sampling regs_q gives the pre-write value on a colliding commit.
  always_comb begin
    case (araddr[3:2])
      2'd0:    rsel = regs_q[0];
      2'd1:    rsel = regs_q[1];
      2'd2:    rsel = regs_q[2];
      default: rsel = ID_VALUE;
    endcase
  end

  // Single-outstanding read channel with one-cycle latency.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q   <= 32'd0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else if (ar_hs) begin
      rdata_q   <= rsel;
      rvalid_q  <= 1'b1;
      arready_q <= 1'b0;
    end else if (rvalid_q && rready) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = RESP_OKAY;
  assign reg0_out = regs_q[0];
  assign reg1_out = regs_q[1];
  assign reg2_out = regs_q[2];

endmodule
